// File: rtl/arb_pkg.sv
// Shared types and matrix helpers for the matrix-arbiter priority controller.
package arb_pkg;

    // Lock FSM: IDLE arbitrates freely, LOCK holds the grant on one owner.
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_lock_st_e;

    // Largest requester count the helper functions cover.
    localparam int ARB_MAX_W = 32;

    // [i][j]=1 means requester j has priority over requester i.
    typedef logic [ARB_MAX_W-1:0][ARB_MAX_W-1:0] arb_mtx_t;

    // Reset ordering: lower index wins, so every row i yields to all j<i.
    function automatic arb_mtx_t arb_mtx_init(input int width);
        arb_mtx_t m;
        m = '0;
        for (int i = 0; i < ARB_MAX_W; i++) begin
            for (int j = 0; j < ARB_MAX_W; j++) begin
                if ((i < width) && (j < i)) begin
                    m[i][j] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    // Least-recently-granted update: g yields to everyone, nobody yields to g.
    function automatic arb_mtx_t arb_mtx_upd(input arb_mtx_t m, input int g, input int width);
        arb_mtx_t r;
        r = m;
        for (int i = 0; i < ARB_MAX_W; i++) begin
            if ((i < width) && (i != g)) begin
                r[g][i] = 1'b1;
                r[i][g] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_matrix_prio.sv
// Priority-state and lock controller sitting upstream of arb_matrix.
// Holds the least-recently-granted priority matrix and the masked request
// vector; takes the combinational one-hot grant back from arb_matrix.
//
// Handshake: a beat transfers (o_fire) in any cycle where i_ready is high and
// the returned grant is nonzero; o_gnt is that grant qualified by i_ready.
// When i_ready is low nothing transfers and no state changes, whatever
// i_grant shows. i_last is only looked at for the granted requester on fire.
module arb_matrix_prio
    import arb_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter bit LOCK_EN = 1'b1,
    localparam int IDW    = $clog2(WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             i_req,
    input  logic [WIDTH-1:0]             i_last,
    input  logic                         i_ready,
    input  logic [WIDTH-1:0]             i_grant,
    output logic [WIDTH-1:0][WIDTH-1:0]  o_matrix,
    output logic [WIDTH-1:0]             o_vld,
    output logic [WIDTH-1:0]             o_gnt,
    output logic                         o_fire,
    output logic                         o_locked,
    output logic [IDW-1:0]               o_lock_id
);

    localparam arb_mtx_t MTX_RST = arb_mtx_init(WIDTH);

    arb_lock_st_e              state;
    arb_lock_st_e              state_nxt;
    logic [IDW-1:0]            owner;
    logic [IDW-1:0]            owner_nxt;
    logic [WIDTH-1:0]          owner_oh;
    logic [IDW-1:0]            gnt_idx;
    logic                      last_g;
    logic                      upd_en;
    logic [WIDTH-1:0][WIDTH-1:0] mtx;
    logic [WIDTH-1:0][WIDTH-1:0] mtx_rst;
    logic [WIDTH-1:0][WIDTH-1:0] mtx_upd;

    // Request masking and grant qualification; o_vld never depends on i_grant.
    always_comb begin
        owner_oh = WIDTH'(1) << owner;
        o_vld    = (state == LOCK) ? (i_req & owner_oh) : i_req;
        o_gnt    = i_grant & {WIDTH{i_ready}};
        o_fire   = |o_gnt;
        o_locked = (state == LOCK);
        o_lock_id = o_locked ? owner : '0;
        o_matrix = mtx;
    end

    // Index of the qualified grant and its last-beat flag.
    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (o_gnt[k]) begin
                gnt_idx = gnt_idx | IDW'(k);
            end
        end
        last_g = |(o_gnt & i_last);
    end

    // Lock FSM next state; a fire with last set in IDLE is a single-beat transfer.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        upd_en    = 1'b0;
        case (state)
            IDLE: begin
                if (o_fire) begin
                    if (LOCK_EN && !last_g) begin
                        state_nxt = LOCK;
                        owner_nxt = gnt_idx;
                    end else begin
                        upd_en = 1'b1;
                    end
                end
            end
            LOCK: begin
                if (o_fire && last_g) begin
                    state_nxt = IDLE;
                    owner_nxt = '0;
                    upd_en    = 1'b1;
                end
            end
        endcase
    end

    // Lock FSM state and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Per-element reset pattern and row/column update for the granted requester.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
        for (genvar gj = 0; gj < WIDTH; gj++) begin : g_col
            if (gi == gj) begin : g_diag
                assign mtx_rst[gi][gj] = 1'b0;
                assign mtx_upd[gi][gj] = 1'b0;
            end else begin : g_off
                assign mtx_rst[gi][gj] = MTX_RST[gi][gj];
                assign mtx_upd[gi][gj] = o_gnt[gi] ? 1'b1 :
                                         o_gnt[gj] ? 1'b0 : mtx[gi][gj];
            end
        end
    end

    // Priority matrix register; only changes on a completing transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtx <= mtx_rst;
        end else if (upd_en) begin
            mtx <= mtx_upd;
        end
    end

    // Matrix must stay antisymmetric with a zero diagonal.
    for (genvar ai = 0; ai < WIDTH; ai++) begin : g_a_row
        a_diag: assert property (@(posedge clk) disable iff (rst) mtx[ai][ai] == 1'b0);
        for (genvar aj = ai + 1; aj < WIDTH; aj++) begin : g_a_col
            a_anti: assert property (@(posedge clk) disable iff (rst) mtx[ai][aj] != mtx[aj][ai]);
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(i_grant));
    a_gnt_in_vld:  assert property (@(posedge clk) disable iff (rst) (i_grant & ~o_vld) == '0);
    a_gnt_nonzero: assert property (@(posedge clk) disable iff (rst) (o_vld != '0) |-> (i_grant != '0));
    a_lock_single: assert property (@(posedge clk) disable iff (rst)
                                    o_locked |-> ($onehot(o_vld) || (o_vld == '0)));

endmodule
